// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Fetch stage that sits directly in front of the decoder/controller. It owns
// the PC and sends one request at a time to the instruction cache. Each fetched
// 32-bit word is presented to the controller together with its PC. A taken
// branch from downstream redirects the PC. Any stale in-flight or held
// instruction is then thrown away.
//
// Handshakes (valid/ready):
//   - A transfer happens on a rising clock edge where both valid and ready
//     are 1.
//   - Once a producer raises valid, it keeps valid and its payload stable
//     until that transfer happens. A redirect is the only exception: it may
//     withdraw the presented instruction.
//   - Ready may change freely and never depends on valid from the same side.
//   - The cache response is a single-cycle pulse (imemRespValid). It has no
//     ready, and it only counts while a request is outstanding.
//
// Ports
//   clock, resetN      rising-edge clock; asynchronous active-low reset
//   imemReqValid/Ready request channel to the cache; imemAddr = pc
//   imemRespValid/Data response pulse and fetched word from the cache
//   instrValid/Ready   instruction channel to the controller
//   instruction        instruction word presented to the controller
//   instrPC            address of the presented instruction
//   redirectValid      load redirectTarget (word aligned) into pc
//   redirectTarget     new PC from branch resolution
//   fetchCount         number of instructions handed over (wraps)
//   dbgState           current FSM state (0 FETCH, 1 WAIT, 2 HOLD)
module instruction_fetch_unit #(
  parameter int unsigned         PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                resetN,
  output logic                imemReqValid,
  input  logic                imemReqReady,
  output logic [PC_WIDTH-1:0] imemAddr,
  input  logic                imemRespValid,
  input  logic [31:0]         imemRespData,
  output logic                instrValid,
  input  logic                instrReady,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] instrPC,
  input  logic                redirectValid,
  input  logic [PC_WIDTH-1:0] redirectTarget,
  output logic [31:0]         fetchCount,
  output logic [1:0]          dbgState
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] inflightPC;
  logic                dropPending;  // the outstanding response belongs to a squashed path
  logic [PC_WIDTH-1:0] redirectPC;

  assign redirectPC = {redirectTarget[PC_WIDTH-1:2], 2'b00};

  // A request is raised only in FETCH. Gating with resetN keeps it low for the
  // whole of reset, even though the state register already reads FETCH then.
  assign imemReqValid = resetN && (state == FETCH);
  assign imemAddr     = pc;
  assign dbgState     = state;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inflightPC  <= '0;
      dropPending <= 1'b0;
      instrValid  <= 1'b0;
      instruction <= '0;
      instrPC     <= '0;
      fetchCount  <= '0;
    end else if (redirectValid) begin
      // A redirect wins over everything else. The held instruction is dropped
      // without being counted, even if instrReady is high in the same cycle.
      pc         <= redirectPC;
      instrValid <= 1'b0;
      case (state)
        FETCH: begin
          if (imemReqReady) begin
            // The cache took the old-path request anyway, so its response
            // must be swallowed.
            state       <= WAIT;
            inflightPC  <= pc;
            dropPending <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        WAIT: begin
          if (imemRespValid) begin
            state       <= FETCH;
            dropPending <= 1'b0;
          end else begin
            state       <= WAIT;
            dropPending <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imemReqReady) begin
            state      <= WAIT;
            inflightPC <= pc;
          end
        end
        WAIT: begin
          if (imemRespValid) begin
            if (dropPending) begin
              dropPending <= 1'b0;
              state       <= FETCH;
            end else begin
              instruction <= imemRespData;
              instrPC     <= inflightPC;
              instrValid  <= 1'b1;
              pc          <= inflightPC + PC_WIDTH'(4);
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (instrReady) begin
            instrValid <= 1'b0;
            fetchCount <= fetchCount + 32'd1;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
